spi_slave_mem: RTL and testbench
================================

# spi_slave_mem

SPI slave (mode 0, CPOL=0/CPHA=0) that sits directly downstream of the SPI master. It consumes the master's SCLK, CS and MOSI, decodes an address/RW byte, and then either writes the following data byte into a 128x8 register memory or shifts the addressed byte back out on MISO. All SPI inputs are asynchronous to the block clock and are conditioned internally before use.

## Interface
- ADDR_W, 7: address bits in the command byte; memory depth is 2^ADDR_W.
- DATA_W, 8: data byte width. Fixed at 8; other values are unsupported.
- SYNC_STAGES, 2: synchronizer flops per SPI input.

- clk  in  1  block clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from the master, asynchronous.
- cs  in  1  chip select, active low, asynchronous.
- mosi  in  1  serial data from the master, MSB first.
- miso  out  1  serial data to the master. Resets to 0.
- miso_oe  out  1  tri-state enable for the pad; high only while a read data byte is being shifted out. Resets to 0.
- frame_done  out  1  one-cycle pulse when a complete read or write frame finishes. Resets to 0.
- wr_strobe  out  1  one-cycle pulse coincident with the memory write. Resets to 0.
- wr_addr  out  ADDR_W  address of the last write. Resets to 0.
- wr_data  out  DATA_W  data of the last write. Resets to 0.

## Operation
- Conditioning: sclk, cs and mosi each pass through SYNC_STAGES flops. sclk_rise and sclk_fall are single-cycle pulses derived from the last two synchronized sclk samples.
- Frame format: cs falls, then byte 0 = {addr[6:0], rw}, with rw=1 meaning read. Byte 1 is the data byte. Both bytes are MSB first.
- mosi is sampled on sclk_rise. miso changes on sclk_fall.
- FSM states:
  - IDLE: bit counter = 0, miso_oe = 0. A synchronized cs of 0 moves to CMD.
  - CMD: shift mosi into the shift register on each sclk_rise. On the 8th rise, latch addr and rw. If rw=1 go to RD_LOAD; otherwise go to WR_SHIFT.
  - RD_LOAD: one cycle. Load mem[addr] into the shift register, then go to RD_SHIFT.
  - RD_SHIFT:
    - On the first sclk_fall (the fall that ends the command byte), set miso_oe=1 and drive bit 7.
    - On each later sclk_fall, drive the next bit.
    - After the 8th data-byte sclk_rise, pulse frame_done and go to DONE.
  - WR_SHIFT: shift mosi on sclk_rise. On the 8th rise go to WR_COMMIT.
  - WR_COMMIT: one cycle. Write mem[addr] <= shift register, pulse wr_strobe, update wr_addr/wr_data, pulse frame_done, go to DONE.
  - DONE: ignore sclk until cs deasserts, then go to IDLE. Extra clocks in the frame are discarded and memory is not modified.
- Abort: synchronized cs=1 in any state except IDLE forces IDLE on the next clk. Consequences:
  - miso_oe drops and miso goes to 0.
  - An incomplete write is discarded: no memory change, no strobes.
  - A read aborted mid-byte produces no frame_done.
- Memory has no reset; contents are undefined until written. Reads are combinational from the addr register.

## Timing
- Input latency: an SPI edge becomes visible as a sclk_rise/sclk_fall pulse SYNC_STAGES+1 clk cycles after the pad transition.
- Constraints:
  - Each sclk high and low phase must be at least SYNC_STAGES+3 clk cycles.
  - cs setup to the first sclk rise must be at least SYNC_STAGES+2 clk cycles.
  - These guarantee that RD_LOAD finishes before the first read sclk_fall.
- A write takes effect 2 clk cycles after the 16th sclk_rise pulse: one cycle to reach WR_COMMIT, then the write edge.
- miso is registered and updates 1 clk cycle after the sclk_fall pulse.
- Simultaneous events:
  - cs deassertion beats any coincident sclk pulse in the same cycle.
  - frame_done and an abort in the same cycle: frame_done still fires, because the frame completed first.
- Asynchronous reset mid-frame returns to IDLE with all outputs at their reset values. The master must restart the frame with a new cs assertion.

## Structure
- Shared package spi_pkg:
  - state enum {IDLE, CMD, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE}.
  - RW_READ = 1'b1.
  - SPI_BYTE = 8.
- Sub-module spi_sync_edge (SYNC_STAGES flops plus edge detect), instantiated three times. The edge outputs are unused for mosi.
- Memory is an inferred array inside spi_slave_mem; no separate module.

## Test plan
- Write then read: write 0xA5 to addr 0x12 (byte0 0x24), then read addr 0x12 (byte0 0x25). Expected:
  - one wr_strobe with wr_addr=0x12 and wr_data=0xA5;
  - miso returns bits 1,0,1,0,0,1,0,1 on successive falls;
  - frame_done pulses once per frame.
- Boundary addresses: write 0xFF to addr 0x7F and 0x00 to addr 0x00, then read both back. Expected 0xFF and 0x00, with no aliasing between the two.
- Abort mid-write: raise cs after 12 sclk rises of a write of 0x3C to addr 0x05. Expected: no wr_strobe, no frame_done, and mem[0x05] keeps its prior value 0x77.
- Overlong frame: 24 sclk cycles in a write of 0x11 to addr 0x40. Expected: exactly one wr_strobe (0x11), and miso_oe stays 0 throughout.
- Async reset mid-read: assert rst_n=0 at read bit 4. Expected: miso=0, miso_oe=0, state IDLE immediately. A following read of the same address returns the correct byte.
- Timing limit: sclk phase of exactly SYNC_STAGES+3 clk cycles. Expected: read data is correct. A checker confirms miso is stable at every sclk rise.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave register memory: widths, FSM state codes
// and protocol constants. Imported by the interface, sub-module and top.
package spi_pkg;

  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned SPI_BYTE    = 8;
  localparam int unsigned CNT_W       = $clog2(SPI_BYTE);
  localparam int unsigned ST_W        = 3;

  localparam logic RW_READ = 1'b1;

  // FSM state codes
  localparam logic [ST_W-1:0] IDLE      = 3'd0;
  localparam logic [ST_W-1:0] CMD       = 3'd1;
  localparam logic [ST_W-1:0] RD_LOAD   = 3'd2;
  localparam logic [ST_W-1:0] RD_SHIFT  = 3'd3;
  localparam logic [ST_W-1:0] WR_SHIFT  = 3'd4;
  localparam logic [ST_W-1:0] WR_COMMIT = 3'd5;
  localparam logic [ST_W-1:0] DONE      = 3'd6;

endpackage

// File: rtl/spi_slave_mem_if.sv
// SPI pad signals plus the write/frame status outputs of the slave.
//   master : drives sclk/cs/mosi, observes everything else
//   slave  : consumes sclk/cs/mosi, drives miso/miso_oe/frame_done/wr_*
interface spi_slave_mem_if #(
  parameter int unsigned ADDR_W = spi_pkg::ADDR_W,
  parameter int unsigned DATA_W = spi_pkg::DATA_W
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              frame_done;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output sclk, cs, mosi,
    input  miso, miso_oe, frame_done, wr_strobe, wr_addr, wr_data
  );

  modport slave (
    input  sclk, cs, mosi,
    output miso, miso_oe, frame_done, wr_strobe, wr_addr, wr_data
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with registered edge
// pulses taken from the last two synchronized samples.
//   clk, rst_n : block clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-cycle edge pulses, SYNC_STAGES+1 cycles after the pad edge
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave with a 2^ADDR_W x DATA_W register memory. Byte 0 of a
// frame is {addr, rw}; byte 1 is written to memory or the addressed byte is
// shifted back out on miso.
//   clk, rst_n : block clock, async active-low reset
//   bus        : slave modport (sclk/cs/mosi in; miso, miso_oe, frame_done,
//                wr_strobe, wr_addr, wr_data out)
module spi_slave_mem
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = spi_pkg::SYNC_STAGES
) (
  input logic             clk,
  input logic             rst_n,
  spi_slave_mem_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BYTE - 1);

  logic sclk_rise, sclk_fall, cs_s, mosi_s;
  logic sclk_q_unused, cs_rise_unused, cs_fall_unused;
  logic mosi_rise_unused, mosi_fall_unused;

  // cs idles high, so its synchronizer resets deasserted
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(bus.sclk),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(bus.cs),
    .q(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(bus.mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_byte_c;

  assign rd_byte_c = mem[addr_q];

  // Memory array: no reset, written only in WR_COMMIT
  always_ff @(posedge clk) begin
    if (state_q == WR_COMMIT) mem[addr_q] <= sh_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      addr_q   <= '0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      addr_q   <= addr_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    addr_d   = addr_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    done_d   = 1'b0;
    strobe_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        oe_d   = 1'b0;
        miso_d = 1'b0;
        if (!cs_s) state_d = CMD;
      end
      CMD: begin
        if (sclk_rise) begin
          sh_d  = {sh_q[DATA_W-2:0], mosi_s};
          cnt_d = cnt_q + CNT_W'(1);
          // on the 8th bit sh_q already holds the address, mosi_s is rw
          if (cnt_q == LAST_BIT) begin
            addr_d  = sh_q[ADDR_W-1:0];
            state_d = (mosi_s == RW_READ) ? RD_LOAD : WR_SHIFT;
          end
        end
      end
      RD_LOAD: begin
        sh_d    = rd_byte_c;
        state_d = RD_SHIFT;
      end
      RD_SHIFT: begin
        if (sclk_fall) begin
          miso_d = sh_q[DATA_W-1];
          sh_d   = {sh_q[DATA_W-2:0], 1'b0};
          oe_d   = 1'b1;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            done_d  = 1'b1;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      WR_SHIFT: begin
        if (sclk_rise) begin
          sh_d  = {sh_q[DATA_W-2:0], mosi_s};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) state_d = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        strobe_d = 1'b1;
        waddr_d  = addr_q;
        wdata_d  = sh_q;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        oe_d   = 1'b0;
        miso_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // cs release aborts; WR_COMMIT has already seen all 16 bits and finishes
    if (cs_s && (state_q != IDLE) && (state_q != WR_COMMIT)) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign bus.miso       = miso_q;
  assign bus.miso_oe    = oe_q;
  assign bus.frame_done = done_q;
  assign bus.wr_strobe  = strobe_q;
  assign bus.wr_addr    = waddr_q;
  assign bus.wr_data    = wdata_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Self-checking bench for spi_slave_mem: a table of directed frames followed
// by random frames checked against an array model of the register memory.
module tb_spi_slave_mem;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_mem_if bus ();

  spi_slave_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Pulse/level monitors sampled on the falling edge
  int         n_strobe = 0;
  int         n_done   = 0;
  int         n_oe     = 0;
  logic [6:0] cap_addr = '0;
  logic [7:0] cap_data = '0;

  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      n_strobe <= n_strobe + 1;
      cap_addr <= bus.wr_addr;
      cap_data <= bus.wr_data;
    end
    if (bus.frame_done) n_done <= n_done + 1;
    if (bus.miso_oe)    n_oe   <= n_oe + 1;
  end

  // Reference memory: byte value and whether it has been written
  logic [7:0] model [128];
  logic       known [128];

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbits;
    int         hp;
    int         strobes;
    int         dones;
    logic [7:0] wdata;
    logic       chk_rd;
    logic [7:0] rd;
    logic       oe;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master side of one frame: nbits sclk pulses with half-period hp clk
  // cycles. rst_bit >= 0 pulls rst_n low just after that rise.
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input int nbits, input int hp, input int rst_bit,
                           output logic [7:0] rx);
    logic [23:0] frm;
    logic        prev;
    frm = {b0, b1, 8'hFF};
    rx  = '0;
    bus.cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = frm[23-i];
      cycles(hp - 1);
      prev = bus.miso;
      cycles(1);
      if (b0[0] && i >= 8 && i < 16)
        chk($sformatf("miso_stable_b%0d", i - 8), 32'(bus.miso), 32'(prev));
      bus.sclk = 1'b1;
      if (i >= 8 && i < 16) rx = {rx[6:0], bus.miso};
      if (i == rst_bit) begin
        cycles(2);
        chk("oe_before_rst", 32'(bus.miso_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_miso", 32'(bus.miso), 32'd0);
        chk("rst_oe", 32'(bus.miso_oe), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_waddr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wdata", 32'(bus.wr_data), 32'd0);
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
        return;
      end
      cycles(hp);
      bus.sclk = 1'b0;
    end
    cycles(hp);
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    cycles(hp + 4);
  endtask

  task automatic model_update(input logic [7:0] b0, input logic [7:0] b1, input int nbits);
    if (!b0[0] && nbits >= 16) begin
      model[b0[7:1]] = b1;
      known[b0[7:1]] = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rx;
    int s0, d0, o0;
    for (int i = 0; i < 128; i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end

    //          b0     b1     nb  hp str dn wdata  rd  rdval  oe
    vt[0]  = '{8'h24, 8'hA5, 16, 6, 1, 1, 8'hA5, 1'b0, 8'h00, 1'b0}; // wr 0x12
    vt[1]  = '{8'h25, 8'h00, 16, 6, 0, 1, 8'h00, 1'b1, 8'hA5, 1'b1}; // rd 0x12
    vt[2]  = '{8'hFE, 8'hFF, 16, 6, 1, 1, 8'hFF, 1'b0, 8'h00, 1'b0}; // wr 0x7F
    vt[3]  = '{8'h00, 8'h00, 16, 6, 1, 1, 8'h00, 1'b0, 8'h00, 1'b0}; // wr 0x00
    vt[4]  = '{8'hFF, 8'h00, 16, 6, 0, 1, 8'h00, 1'b1, 8'hFF, 1'b1}; // rd 0x7F
    vt[5]  = '{8'h01, 8'h00, 16, 6, 0, 1, 8'h00, 1'b1, 8'h00, 1'b1}; // rd 0x00
    vt[6]  = '{8'h0A, 8'h77, 16, 6, 1, 1, 8'h77, 1'b0, 8'h00, 1'b0}; // wr 0x05
    vt[7]  = '{8'h0A, 8'h3C, 12, 6, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0}; // aborted wr
    vt[8]  = '{8'h0B, 8'h00, 16, 6, 0, 1, 8'h00, 1'b1, 8'h77, 1'b1}; // rd 0x05
    vt[9]  = '{8'h80, 8'h11, 24, 6, 1, 1, 8'h11, 1'b0, 8'h00, 1'b0}; // overlong wr
    vt[10] = '{8'h81, 8'h00, 16, 6, 0, 1, 8'h00, 1'b1, 8'h11, 1'b1}; // rd 0x40
    vt[11] = '{8'h25, 8'h00, 16, 5, 0, 1, 8'h00, 1'b1, 8'hA5, 1'b1}; // rd at min phase
    vt[12] = '{8'hFF, 8'h00, 12, 6, 0, 0, 8'h00, 1'b0, 8'h00, 1'b1}; // aborted rd
    vt[13] = '{8'hFE, 8'h5A, 16, 5, 1, 1, 8'h5A, 1'b0, 8'h00, 1'b0}; // wr at min phase

    rst_n    = 1'b0;
    bus.sclk = 1'b0;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    cycles(4);
    rst_n = 1'b1;
    cycles(4);
    chk("reset_miso", 32'(bus.miso), 32'd0);
    chk("reset_oe", 32'(bus.miso_oe), 32'd0);
    chk("reset_done", 32'(bus.frame_done), 32'd0);
    chk("reset_strobe", 32'(bus.wr_strobe), 32'd0);
    chk("reset_waddr", 32'(bus.wr_addr), 32'd0);
    chk("reset_wdata", 32'(bus.wr_data), 32'd0);

    for (int i = 0; i < 14; i++) begin
      s0 = n_strobe; d0 = n_done; o0 = n_oe;
      spi_frame(vt[i].b0, vt[i].b1, vt[i].nbits, vt[i].hp, -1, rx);
      chk($sformatf("v%0d_strobes", i), 32'(n_strobe - s0), 32'(vt[i].strobes));
      chk($sformatf("v%0d_dones", i), 32'(n_done - d0), 32'(vt[i].dones));
      chk($sformatf("v%0d_oe_seen", i), 32'(n_oe != o0), 32'(vt[i].oe));
      if (vt[i].strobes != 0) begin
        chk($sformatf("v%0d_waddr", i), 32'(cap_addr), 32'(vt[i].b0[7:1]));
        chk($sformatf("v%0d_wdata", i), 32'(cap_data), 32'(vt[i].wdata));
      end
      if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), 32'(rx), 32'(vt[i].rd));
      model_update(vt[i].b0, vt[i].b1, vt[i].nbits);
    end

    // Async reset during read data bit 4, then the same read again
    d0 = n_done;
    spi_frame(8'h25, 8'h00, 16, 6, 12, rx);
    chk("rstrd_no_done", 32'(n_done - d0), 32'd0);
    spi_frame(8'h25, 8'h00, 16, 6, -1, rx);
    chk("rstrd_reread", 32'(rx), 32'(model[7'h12]));

    // Random frames against the array model
    for (int k = 0; k < 40; k++) begin
      logic [6:0] a;
      logic [7:0] d, b0;
      logic       rd;
      int         nb, hp;
      a  = 7'($urandom_range(0, 127));
      d  = 8'($urandom);
      rd = known[a] && ($urandom_range(0, 1) == 1);
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : 16;
      hp = $urandom_range(5, 8);
      b0 = {a, rd};
      s0 = n_strobe; d0 = n_done; o0 = n_oe;
      spi_frame(b0, d, nb, hp, -1, rx);
      chk($sformatf("r%0d_strobes", k), 32'(n_strobe - s0), 32'((!rd && nb == 16) ? 1 : 0));
      chk($sformatf("r%0d_dones", k), 32'(n_done - d0), 32'((nb == 16) ? 1 : 0));
      if (!rd) chk($sformatf("r%0d_no_oe", k), 32'(n_oe - o0), 32'd0);
      if (!rd && nb == 16) begin
        chk($sformatf("r%0d_waddr", k), 32'(cap_addr), 32'(a));
        chk($sformatf("r%0d_wdata", k), 32'(cap_data), 32'(d));
      end
      if (rd && nb == 16) chk($sformatf("r%0d_rdata", k), 32'(rx), 32'(model[a]));
      model_update(b0, d, nb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
